// File: rtl/ariane_axi.sv
// AXI4 channel and bundle types (64-bit address/data, 4-bit ID) for the shim and its users.
package ariane_axi;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [5:0]  atop;
    logic [0:0]  user;
  } aw_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
    logic [0:0]  user;
  } w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
    logic [0:0] user;
  } b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [0:0]  user;
  } ar_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [0:0]  user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;

endpackage

// File: rtl/axi_shim_ot.sv
// Request/grant to AXI4 master shim limiting in-flight reads and writes to MaxOutstanding each.
// Define AXI_SHIM_OT_ERR_EN to get registered SLVERR/DECERR pulses on wr_err_o / rd_err_o.
module axi_shim_ot #(
  parameter int unsigned AxiNumWords    = 4,
  parameter int unsigned AxiAddrWidth   = 64,
  parameter int unsigned AxiDataWidth   = 64,
  parameter int unsigned AxiIdWidth     = 4,
  parameter int unsigned MaxOutstanding = 4,
  parameter type         axi_req_t      = ariane_axi::req_t,
  parameter type         axi_rsp_t      = ariane_axi::resp_t,
  localparam int unsigned BlenWidth     = (AxiNumWords > 1) ? $clog2(AxiNumWords) : 1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  rd_req_i,
  output logic                                  rd_gnt_o,
  input  logic [AxiAddrWidth-1:0]               rd_addr_i,
  input  logic [BlenWidth-1:0]                  rd_blen_i,
  input  logic [AxiIdWidth-1:0]                 rd_id_i,
  input  logic                                  rd_rdy_i,
  output logic                                  rd_valid_o,
  output logic                                  rd_last_o,
  output logic [AxiDataWidth-1:0]               rd_data_o,
  output logic [AxiIdWidth-1:0]                 rd_id_o,
  input  logic                                  wr_req_i,
  output logic                                  wr_gnt_o,
  input  logic [AxiAddrWidth-1:0]               wr_addr_i,
  input  logic [AxiNumWords*AxiDataWidth-1:0]   wr_data_i,
  input  logic [AxiNumWords*AxiDataWidth/8-1:0] wr_be_i,
  input  logic [BlenWidth-1:0]                  wr_blen_i,
  input  logic [AxiIdWidth-1:0]                 wr_id_i,
  input  logic                                  wr_rdy_i,
  output logic                                  wr_valid_o,
  output logic [AxiIdWidth-1:0]                 wr_id_o,
  output logic                                  wr_err_o,
  output logic                                  rd_err_o,
  output axi_req_t                              axi_req_o,
  input  axi_rsp_t                              axi_resp_i
);

  localparam int unsigned         CntWidth = $clog2(MaxOutstanding + 1);
  localparam logic [CntWidth-1:0] MaxCnt   = CntWidth'(MaxOutstanding);
  localparam logic [2:0]          AxiSize  = 3'($clog2(AxiDataWidth / 8));

  typedef enum logic [1:0] {W_IDLE, W_ACTIVE, W_STALL} wr_state_e;

  wr_state_e            state_q, state_d;
  logic                 aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [BlenWidth-1:0] wcnt_q, wcnt_d;
  logic [CntWidth-1:0]  wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic                 wr_active, aw_valid, w_valid, w_last, aw_hs, w_hs, wr_gnt;
  logic                 b_hs, ar_valid, ar_hs, r_last_hs;

  logic [AxiNumWords-1:0][AxiDataWidth-1:0]   wr_beats;
  logic [AxiNumWords-1:0][AxiDataWidth/8-1:0] wr_strbs;

  assign wr_beats  = wr_data_i;
  assign wr_strbs  = wr_be_i;
  assign b_hs      = axi_resp_i.b_valid & wr_rdy_i;
  assign ar_valid  = rd_req_i & (rd_cnt_q < MaxCnt);
  assign ar_hs     = ar_valid & axi_resp_i.ar_ready;
  assign r_last_hs = axi_resp_i.r_valid & rd_rdy_i & axi_resp_i.r.last;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    wcnt_d    = wcnt_q;
    wr_active = 1'b0;
    unique case (state_q)
      W_IDLE: begin
        if (wr_req_i) begin
          if (wr_cnt_q < MaxCnt) wr_active = 1'b1;
          else                   state_d   = W_STALL;
        end
      end
      W_ACTIVE: wr_active = 1'b1;
      // No grant can happen while stalled, so a B handshake is the only way the count drops.
      W_STALL:  if ((wr_cnt_q < MaxCnt) || b_hs) state_d = W_IDLE;
      default:  state_d = W_IDLE;
    endcase

    aw_valid = wr_active & ~aw_done_q;
    w_valid  = wr_active & ~w_done_q;
    w_last   = (wcnt_q == wr_blen_i);
    aw_hs    = aw_valid & axi_resp_i.aw_ready;
    w_hs     = w_valid & axi_resp_i.w_ready;
    wr_gnt   = wr_active & (aw_done_q | aw_hs) & (w_done_q | (w_hs & w_last));

    if (wr_gnt) begin
      state_d   = W_IDLE;
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
      wcnt_d    = '0;
    end else if (wr_active) begin
      state_d   = W_ACTIVE;
      aw_done_d = aw_done_q | aw_hs;
      w_done_d  = w_done_q | (w_hs & w_last);
      if (w_hs && !w_last) wcnt_d = wcnt_q + 1'b1;
    end
  end

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if (wr_gnt && !b_hs)      wr_cnt_d = wr_cnt_q + 1'b1;
    else if (!wr_gnt && b_hs) wr_cnt_d = wr_cnt_q - 1'b1;
    rd_cnt_d = rd_cnt_q;
    if (ar_hs && !r_last_hs)      rd_cnt_d = rd_cnt_q + 1'b1;
    else if (!ar_hs && r_last_hs) rd_cnt_d = rd_cnt_q - 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= W_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      wcnt_q    <= '0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      wcnt_q    <= wcnt_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
    end
  end

  // Valids and grants are masked by reset so a held request cannot leak out while in reset.
  always_comb begin
    axi_req_o          = '0;
    axi_req_o.aw.id    = wr_id_i;
    axi_req_o.aw.addr  = wr_addr_i;
    axi_req_o.aw.len   = 8'(wr_blen_i);
    axi_req_o.aw.size  = AxiSize;
    axi_req_o.aw.burst = 2'b01;
    axi_req_o.aw.cache = 4'b0010;
    axi_req_o.aw_valid = aw_valid & rst_ni;
    axi_req_o.w.data   = wr_beats[wcnt_q];
    axi_req_o.w.strb   = wr_strbs[wcnt_q];
    axi_req_o.w.last   = w_last;
    axi_req_o.w_valid  = w_valid & rst_ni;
    axi_req_o.b_ready  = wr_rdy_i;
    axi_req_o.ar.id    = rd_id_i;
    axi_req_o.ar.addr  = rd_addr_i;
    axi_req_o.ar.len   = 8'(rd_blen_i);
    axi_req_o.ar.size  = AxiSize;
    axi_req_o.ar.burst = 2'b01;
    axi_req_o.ar.cache = 4'b0010;
    axi_req_o.ar_valid = ar_valid & rst_ni;
    axi_req_o.r_ready  = rd_rdy_i;
  end

  assign wr_gnt_o   = wr_gnt & rst_ni;
  assign rd_gnt_o   = ar_hs & rst_ni;
  assign rd_valid_o = axi_resp_i.r_valid;
  assign rd_last_o  = axi_resp_i.r.last;
  assign rd_data_o  = axi_resp_i.r.data;
  assign rd_id_o    = axi_resp_i.r.id;
  assign wr_valid_o = axi_resp_i.b_valid;
  assign wr_id_o    = axi_resp_i.b.id;

`ifdef AXI_SHIM_OT_ERR_EN
  logic wr_err_q, rd_err_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      wr_err_q <= b_hs & axi_resp_i.b.resp[1];
      rd_err_q <= axi_resp_i.r_valid & rd_rdy_i & axi_resp_i.r.resp[1];
    end
  end
  assign wr_err_o = wr_err_q;
  assign rd_err_o = rd_err_q;
`else
  assign wr_err_o = 1'b0;
  assign rd_err_o = 1'b0;
`endif

  logic unused_rsp;
  assign unused_rsp = ^{axi_resp_i.b.resp, axi_resp_i.b.user, axi_resp_i.r.resp, axi_resp_i.r.user};

endmodule

// File: tb/tb_axi_shim_ot.sv
// Self-checking bench for axi_shim_ot: directed corner cases plus randomized traffic vs a flag/counter model.
module tb_axi_shim_ot;

  localparam int MAX = 2;
`ifdef AXI_SHIM_OT_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         wr_req, rd_req, wr_rdy, rd_rdy;
  logic [63:0]  wr_addr, rd_addr;
  logic [255:0] wr_data;
  logic [31:0]  wr_be;
  logic [1:0]   wr_blen, rd_blen;
  logic [3:0]   wr_id, rd_id;
  logic         wr_gnt, rd_gnt, rd_valid, rd_last, wr_valid, wr_err, rd_err;
  logic [63:0]  rd_data;
  logic [3:0]   rd_id_out, wr_id_out;
  ariane_axi::req_t  axi_req;
  ariane_axi::resp_t axi_rsp;

  axi_shim_ot #(.MaxOutstanding(MAX)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .rd_req_i(rd_req), .rd_gnt_o(rd_gnt), .rd_addr_i(rd_addr), .rd_blen_i(rd_blen),
    .rd_id_i(rd_id), .rd_rdy_i(rd_rdy), .rd_valid_o(rd_valid), .rd_last_o(rd_last),
    .rd_data_o(rd_data), .rd_id_o(rd_id_out),
    .wr_req_i(wr_req), .wr_gnt_o(wr_gnt), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .wr_be_i(wr_be), .wr_blen_i(wr_blen), .wr_id_i(wr_id), .wr_rdy_i(wr_rdy),
    .wr_valid_o(wr_valid), .wr_id_o(wr_id_out), .wr_err_o(wr_err), .rd_err_o(rd_err),
    .axi_req_o(axi_req), .axi_resp_i(axi_rsp)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state: in-flight counts, progress of the current write, and the "waiting at limit" flag.
  int m_wr_out = 0, m_rd_out = 0, m_beats = 0;
  bit m_busy = 0, m_aw_sent = 0, m_blocked = 0, m_wr_err = 0, m_rd_err = 0;
  bit m_wr_gnt_prev = 0, m_rd_gnt_prev = 0;

  always @(negedge clk) begin : model
    bit act, aw_exp, w_exp, aw_hs, w_hs, aw_fin, w_fin, gnt, b_hs, ar_v, r_hs;
    if (!rst_n) begin
      check("rst aw_valid", axi_req.aw_valid, 0);
      check("rst w_valid", axi_req.w_valid, 0);
      check("rst ar_valid", axi_req.ar_valid, 0);
      check("rst wr_gnt", wr_gnt, 0);
      check("rst rd_gnt", rd_gnt, 0);
      check("rst wr_err", wr_err, 0);
      check("rst rd_err", rd_err, 0);
      m_wr_out = 0; m_rd_out = 0; m_beats = 0; m_busy = 0; m_aw_sent = 0; m_blocked = 0;
      m_wr_err = 0; m_rd_err = 0; m_wr_gnt_prev = 0; m_rd_gnt_prev = 0;
    end else begin
      act    = m_busy || (wr_req && !m_blocked && m_wr_out < MAX);
      aw_exp = act && !m_aw_sent;
      w_exp  = act && (m_beats <= int'(wr_blen));
      aw_hs  = aw_exp && axi_rsp.aw_ready;
      w_hs   = w_exp && axi_rsp.w_ready;
      aw_fin = m_aw_sent || aw_hs;
      w_fin  = (m_beats + int'(w_hs)) > int'(wr_blen);
      gnt    = act && aw_fin && w_fin;
      b_hs   = axi_rsp.b_valid && wr_rdy;
      ar_v   = rd_req && (m_rd_out < MAX);
      r_hs   = axi_rsp.r_valid && rd_rdy;

      check("aw_valid", axi_req.aw_valid, aw_exp);
      check("w_valid", axi_req.w_valid, w_exp);
      check("wr_gnt", wr_gnt, gnt);
      check("ar_valid", axi_req.ar_valid, ar_v);
      check("rd_gnt", rd_gnt, ar_v && axi_rsp.ar_ready);
      check("wr_err", wr_err, m_wr_err);
      check("rd_err", rd_err, m_rd_err);
      if (aw_exp) begin
        check("aw_addr", axi_req.aw.addr, wr_addr);
        check("aw_id", axi_req.aw.id, wr_id);
        check("aw_len", axi_req.aw.len, wr_blen);
        check("aw_size", axi_req.aw.size, 3);
        check("aw_burst", axi_req.aw.burst, 1);
        check("aw_cache", axi_req.aw.cache, 2);
        check("aw_zero", {axi_req.aw.prot, axi_req.aw.qos, axi_req.aw.region,
                          axi_req.aw.lock, axi_req.aw.atop, axi_req.aw.user}, 0);
      end
      if (w_exp) begin
        check("w_data", axi_req.w.data, wr_data[m_beats*64 +: 64]);
        check("w_strb", axi_req.w.strb, wr_be[m_beats*8 +: 8]);
        check("w_last", axi_req.w.last, m_beats == int'(wr_blen));
      end
      if (ar_v) begin
        check("ar_addr", axi_req.ar.addr, rd_addr);
        check("ar_id", axi_req.ar.id, rd_id);
        check("ar_len", axi_req.ar.len, rd_blen);
        check("ar_size_burst", {axi_req.ar.size, axi_req.ar.burst, axi_req.ar.cache}, {3'd3, 2'd1, 4'd2});
      end
      check("r_ready", axi_req.r_ready, rd_rdy);
      check("b_ready", axi_req.b_ready, wr_rdy);
      check("rd_valid", rd_valid, axi_rsp.r_valid);
      check("wr_valid", wr_valid, axi_rsp.b_valid);
      if (axi_rsp.r_valid) begin
        check("rd_data", rd_data, axi_rsp.r.data);
        check("rd_id", rd_id_out, axi_rsp.r.id);
        check("rd_last", rd_last, axi_rsp.r.last);
      end
      if (axi_rsp.b_valid) check("wr_id", wr_id_out, axi_rsp.b.id);

      m_wr_out = m_wr_out + int'(gnt) - int'(b_hs);
      m_rd_out = m_rd_out + int'(ar_v && axi_rsp.ar_ready) - int'(r_hs && axi_rsp.r.last);
      if (m_blocked)            m_blocked = (m_wr_out >= MAX);
      else if (!act && wr_req)  m_blocked = 1'b1;
      if (gnt) begin
        m_busy = 0; m_aw_sent = 0; m_beats = 0;
      end else if (act) begin
        m_busy = 1; m_aw_sent = aw_fin; m_beats += int'(w_hs);
      end
      m_wr_gnt_prev = gnt;
      m_rd_gnt_prev = ar_v && axi_rsp.ar_ready;
      m_wr_err = ErrEn && b_hs && axi_rsp.b.resp[1];
      m_rd_err = ErrEn && r_hs && axi_rsp.r.resp[1];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic new_wr_op();
    for (int i = 0; i < 8; i++) wr_data[i*32 +: 32] = $urandom;
    wr_addr = {$urandom, $urandom};
    wr_be   = $urandom;
    wr_id   = 4'($urandom);
  endtask

  task automatic new_rd_op();
    rd_addr = {$urandom, $urandom};
    rd_blen = 2'($urandom_range(0, 3));
    rd_id   = 4'($urandom);
  endtask

  initial begin
    rst_n = 1'b0;
    wr_req = 0; rd_req = 0; wr_rdy = 0; rd_rdy = 0;
    wr_addr = '0; rd_addr = '0; wr_data = '0; wr_be = '0;
    wr_blen = '0; rd_blen = '0; wr_id = '0; rd_id = '0;
    axi_rsp = '0;
    repeat (2) tick();
    rst_n = 1'b1;

    // Single write with both channels ready completes in one cycle.
    new_wr_op(); wr_req = 1; wr_blen = 0;
    axi_rsp.aw_ready = 1; axi_rsp.w_ready = 1;
    sample();
    check("single aw_valid", axi_req.aw_valid, 1);
    check("single w_valid", axi_req.w_valid, 1);
    check("single w_last", axi_req.w.last, 1);
    check("single wr_gnt", wr_gnt, 1);
    tick(); wr_req = 0;
    sample();
    check("single wr_cnt", dut.wr_cnt_q, 1);
    check("single gnt once", wr_gnt, 0);
    tick(); axi_rsp.b_valid = 1; wr_rdy = 1;
    tick(); axi_rsp.b_valid = 0;
    sample();
    check("drain wr_cnt", dut.wr_cnt_q, 0);

    // Four-beat burst with AW held off until cycle 5.
    tick(); new_wr_op(); wr_req = 1; wr_blen = 3; axi_rsp.w_ready = 1;
    for (int k = 0; k < 6; k++) begin
      axi_rsp.aw_ready = (k == 5);
      sample();
      check("burst w_valid", axi_req.w_valid, k < 4);
      if (k < 4) begin
        check("burst w_data", axi_req.w.data, wr_data[k*64 +: 64]);
        check("burst w_last", axi_req.w.last, k == 3);
      end
      check("burst wr_gnt", wr_gnt, k == 5);
      tick();
    end
    wr_req = 0;
    sample();
    check("burst gnt over", wr_gnt, 0);
    tick(); axi_rsp.b_valid = 1;
    tick(); axi_rsp.b_valid = 0;
    sample();
    check("burst drain", dut.wr_cnt_q, 0);

    // Three back-to-back writes against a limit of two, B released in cycle 4.
    tick(); wr_req = 1; wr_blen = 0; new_wr_op();
    for (int c = 0; c < 6; c++) begin
      axi_rsp.b_valid = (c == 4);
      sample();
      check("limit aw_valid", axi_req.aw_valid, (c < 2) || (c == 5));
      check("limit w_valid", axi_req.w_valid, (c < 2) || (c == 5));
      check("limit wr_gnt", wr_gnt, (c < 2) || (c == 5));
      tick();
      new_wr_op();
    end
    wr_req = 0; axi_rsp.b_valid = 0;
    sample();
    check("limit wr_cnt", dut.wr_cnt_q, 2);

    // Grant and B in the same cycle leave the write count unchanged.
    tick(); axi_rsp.b_valid = 1;
    tick(); wr_req = 1; new_wr_op();
    sample();
    check("same-cycle wr_gnt", wr_gnt, 1);
    tick(); wr_req = 0; axi_rsp.b_valid = 0;
    sample();
    check("same-cycle wr_cnt", dut.wr_cnt_q, 1);
    tick(); axi_rsp.b_valid = 1;
    tick(); axi_rsp.b_valid = 0;

    // AR and last R in the same cycle leave the read count unchanged; then an SLVERR beat.
    new_rd_op(); rd_req = 1; rd_blen = 2; axi_rsp.ar_ready = 1; rd_rdy = 1;
    sample();
    check("rd first gnt", rd_gnt, 1);
    tick(); new_rd_op(); axi_rsp.r_valid = 1; axi_rsp.r.last = 1; axi_rsp.r.resp = 2'b00;
    sample();
    check("rd same-cycle gnt", rd_gnt, 1);
    tick(); rd_req = 0; axi_rsp.r_valid = 0;
    sample();
    check("rd same-cycle cnt", dut.rd_cnt_q, 1);
    tick(); axi_rsp.r_valid = 1; axi_rsp.r.last = 1; axi_rsp.r.resp = 2'b10;
    sample();
    check("rd_err before", rd_err, 0);
    tick(); axi_rsp.r_valid = 0; axi_rsp.r.resp = 2'b00;
    sample();
    check("rd_err pulse", rd_err, ErrEn);
    check("rd drain cnt", dut.rd_cnt_q, 0);
    tick();
    sample();
    check("rd_err one cycle", rd_err, 0);

    // Reset in the middle of a burst abandons it; the held request restarts at beat 0.
    tick(); new_wr_op(); wr_req = 1; wr_blen = 3; axi_rsp.aw_ready = 0; axi_rsp.w_ready = 1;
    new_rd_op(); rd_req = 1; axi_rsp.ar_ready = 0;
    tick();
    tick(); rst_n = 0;
    sample();
    check("midrst aw_valid", axi_req.aw_valid, 0);
    check("midrst w_valid", axi_req.w_valid, 0);
    check("midrst ar_valid", axi_req.ar_valid, 0);
    check("midrst wr_gnt", wr_gnt, 0);
    check("midrst rd_gnt", rd_gnt, 0);
    tick(); rst_n = 1;
    sample();
    check("restart w_data", axi_req.w.data, wr_data[63:0]);
    check("restart aw_valid", axi_req.aw_valid, 1);

    // Randomized traffic: requests held until granted, slave responses only while something is in flight.
    for (int n = 0; n < 4000; n++) begin
      tick();
      rst_n = ($urandom_range(0, 599) != 0);
      if (!wr_req || m_wr_gnt_prev) begin
        wr_req = ($urandom_range(0, 2) != 0);
        wr_blen = 2'($urandom_range(0, 3));
        new_wr_op();
      end
      if (!rd_req || m_rd_gnt_prev) begin
        rd_req = ($urandom_range(0, 2) != 0);
        new_rd_op();
      end
      axi_rsp.aw_ready = ($urandom_range(0, 3) != 0);
      axi_rsp.w_ready  = ($urandom_range(0, 3) != 0);
      axi_rsp.ar_ready = ($urandom_range(0, 3) != 0);
      wr_rdy = ($urandom_range(0, 3) != 0);
      rd_rdy = ($urandom_range(0, 3) != 0);
      axi_rsp.b_valid = (m_wr_out > 0) && ($urandom_range(0, 2) == 0);
      axi_rsp.b.id    = 4'($urandom);
      axi_rsp.b.resp  = 2'($urandom);
      axi_rsp.r_valid = (m_rd_out > 0) && ($urandom_range(0, 1) == 0);
      axi_rsp.r.id    = 4'($urandom);
      axi_rsp.r.data  = {$urandom, $urandom};
      axi_rsp.r.resp  = 2'($urandom);
      axi_rsp.r.last  = ($urandom_range(0, 2) == 0);
    end

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
